cpu_ctrl_seq: RTL and testbench



---
 rtl/cpu_pkg.sv | 37 +++
 rtl/cpu_wait_ctr.sv | 38 +++
 rtl/cpu_ctrl_seq.sv | 210 +++++++++++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the 8-bit accumulator CPU microsequencer.
//   - state encodings (4-bit, reported on the debug state port)
//   - opcode values (upper nibble of IR)
//   - A-register bus source select encodings
//   - is_mem_op(): opcodes that perform an operand memory access in E1
package cpu_pkg;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_F0   = 4'd1;
    localparam logic [3:0] ST_F1   = 4'd2;
    localparam logic [3:0] ST_E0   = 4'd3;
    localparam logic [3:0] ST_E1   = 4'd4;
    localparam logic [3:0] ST_E2   = 4'd5;
    localparam logic [3:0] ST_HALT = 4'd6;
    localparam logic [3:0] ST_WAIT = 4'd7;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JC  = 4'd7;
    localparam logic [3:0] OP_JZ  = 4'd8;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    localparam logic [1:0] ASRC_MEM = 2'd0;
    localparam logic [1:0] ASRC_ALU = 2'd1;
    localparam logic [1:0] ASRC_IMM = 2'd2;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA);
    endfunction

endpackage

// File: rtl/cpu_wait_ctr.sv
// cpu_wait_ctr: memory wait-state down-counter.
// Loaded with WAIT_MEM on the cycle before a memory cycle begins, then counts
// down while the memory cycle is in progress; last is high when the count has
// reached zero, i.e. in the final cycle of the stretched memory access.
// Ports:
//   clk   in  core clock
//   rst   in  asynchronous active-high reset (count clears to 0)
//   load  in  reload count with WAIT_MEM
//   en    in  decrement (saturates at 0)
//   last  out terminal count reached
module cpu_wait_ctr #(
    parameter int unsigned WAIT_MEM = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic last
);
    import cpu_pkg::*;

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_MEM);

    logic [2:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 3'd0;
        end else if (load) begin
            cnt_q <= WAIT_INIT;
        end else if (en && (cnt_q != 3'd0)) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    assign last = (cnt_q == 3'd0);

endmodule

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: fetch/execute microsequencer for the 8-bit accumulator CPU.
// Drives the datapath control strobes (MAR, memory, IR, PC, A/B, ALU, OUT)
// from the state register, the current opcode and the C/Z flags (Moore).
// Optional feature macro: CTRL_SINGLE_STEP_EN -- when defined, step_mode=1
// parks the sequencer in WAIT after every instruction until step is pulsed or
// step_mode is cleared. Without it step_mode/step are ignored.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start                    leave IDLE/HALT and fetch
//   opcode[OP_W-1:0]         IR upper nibble, valid from E0 onward
//   flag_c, flag_z           ALU flags, sampled in E0 only
//   step_mode, step          single-step controls
//   mar_ld_pc..out_ld        datapath strobes
//   a_src[1:0]               A bus source (0 mem, 1 ALU, 2 IR[3:0])
//   instr_done, illegal      per-instruction status pulses
//   halted, state[3:0]       status / debug
//
// state | meaning
// IDLE  | after reset, waiting for start
// F0    | MAR <- PC
// F1    | memory read into IR, PC+1 (wait-stretched)
// E0    | decode; single-cycle ops complete here
// E1    | operand memory access (wait-stretched)
// E2    | ALU result into A, flags latched
// HALT  | stopped by HLT, waiting for start
// WAIT  | single-step hold between instructions
module cpu_ctrl_seq #(
    parameter int unsigned WAIT_MEM = 0,
    parameter int unsigned OP_W     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] opcode,
    input  logic            flag_c,
    input  logic            flag_z,
    input  logic            step_mode,
    input  logic            step,
    output logic            mar_ld_pc,
    output logic            mar_ld_ir,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            ir_ld,
    output logic            pc_inc,
    output logic            pc_ld,
    output logic            a_ld,
    output logic [1:0]      a_src,
    output logic            b_ld,
    output logic            alu_sub,
    output logic            flags_ld,
    output logic            out_ld,
    output logic            instr_done,
    output logic            illegal,
    output logic            halted,
    output logic [3:0]      state
);
    import cpu_pkg::*;

    logic [3:0] state_q;
    logic [3:0] state_nxt;
    logic [3:0] done_nxt;
    logic [3:0] op;
    logic       wait_load;
    logic       wait_en;
    logic       wait_last;

    assign op = opcode[OP_W-1 -: 4];

    // Reload the wait counter one cycle before each memory cycle starts.
    assign wait_load = (state_q == ST_F0) || ((state_q == ST_E0) && is_mem_op(op));
    assign wait_en   = (state_q == ST_F1) || (state_q == ST_E1);

    cpu_wait_ctr #(.WAIT_MEM(WAIT_MEM)) u_wait_ctr (
        .clk  (clk),
        .rst  (rst),
        .load (wait_load),
        .en   (wait_en),
        .last (wait_last)
    );

`ifdef CTRL_SINGLE_STEP_EN
    assign done_nxt = step_mode ? ST_WAIT : ST_F0;
`else
    logic unused_step;
    assign unused_step = step_mode ^ step;
    assign done_nxt    = ST_F0;
`endif

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (start) state_nxt = ST_F0;
            ST_F0:   state_nxt = ST_F1;
            ST_F1:   if (wait_last) state_nxt = ST_E0;
            ST_E0: begin
                if (is_mem_op(op))      state_nxt = ST_E1;
                else if (op == OP_HLT)  state_nxt = ST_HALT;
                else                    state_nxt = done_nxt;
            end
            ST_E1: begin
                if (wait_last) begin
                    if ((op == OP_ADD) || (op == OP_SUB)) state_nxt = ST_E2;
                    else                                  state_nxt = done_nxt;
                end
            end
            ST_E2:   state_nxt = done_nxt;
            ST_HALT: if (start) state_nxt = ST_F0;
`ifdef CTRL_SINGLE_STEP_EN
            ST_WAIT: if (!step_mode || step) state_nxt = ST_F0;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        mar_ld_pc  = 1'b0;
        mar_ld_ir  = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_ld      = 1'b0;
        pc_inc     = 1'b0;
        pc_ld      = 1'b0;
        a_ld       = 1'b0;
        a_src      = ASRC_MEM;
        b_ld       = 1'b0;
        alu_sub    = 1'b0;
        flags_ld   = 1'b0;
        out_ld     = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            ST_F0: mar_ld_pc = 1'b1;
            ST_F1: begin
                mem_rd = 1'b1;
                ir_ld  = wait_last;
                pc_inc = wait_last;
            end
            ST_E0: begin
                case (op)
                    OP_NOP: instr_done = 1'b1;
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_ld_ir = 1'b1;
                    OP_LDI: begin
                        a_ld       = 1'b1;
                        a_src      = ASRC_IMM;
                        instr_done = 1'b1;
                    end
                    OP_JMP: begin
                        pc_ld      = 1'b1;
                        instr_done = 1'b1;
                    end
                    OP_JC: begin
                        pc_ld      = flag_c;
                        instr_done = 1'b1;
                    end
                    OP_JZ: begin
                        pc_ld      = flag_z;
                        instr_done = 1'b1;
                    end
                    OP_OUT: begin
                        out_ld     = 1'b1;
                        instr_done = 1'b1;
                    end
                    OP_HLT: instr_done = 1'b1;
                    default: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            ST_E1: begin
                case (op)
                    OP_LDA: begin
                        mem_rd     = 1'b1;
                        a_ld       = wait_last;
                        instr_done = wait_last;
                    end
                    OP_ADD, OP_SUB: begin
                        mem_rd = 1'b1;
                        b_ld   = wait_last;
                    end
                    OP_STA: begin
                        mem_wr     = 1'b1;
                        instr_done = wait_last;
                    end
                    default: ;
                endcase
            end
            ST_E2: begin
                a_ld       = 1'b1;
                a_src      = ASRC_ALU;
                flags_ld   = 1'b1;
                alu_sub    = (op == OP_SUB);
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign halted = (state_q == ST_HALT);
    assign state  = state_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
module tb_cpu_ctrl_seq;

    localparam logic [3:0] E_IDLE = 4'd0, E_F0 = 4'd1, E_F1 = 4'd2, E_E0 = 4'd3;
    localparam logic [3:0] E_E1 = 4'd4, E_E2 = 4'd5, E_HALT = 4'd6, E_WAIT = 4'd7;

    localparam logic [15:0] C_MPC = 16'h8000, C_MIR = 16'h4000, C_MRD = 16'h2000;
    localparam logic [15:0] C_MWR = 16'h1000, C_IRL = 16'h0800, C_PCI = 16'h0400;
    localparam logic [15:0] C_PCL = 16'h0200, C_ALD = 16'h0100, C_AS2 = 16'h0080;
    localparam logic [15:0] C_AS1 = 16'h0040, C_BLD = 16'h0020, C_SUB = 16'h0010;
    localparam logic [15:0] C_FLD = 16'h0008, C_OUT = 16'h0004, C_DONE = 16'h0002;
    localparam logic [15:0] C_ILL = 16'h0001;
    localparam logic [15:0] C_FETCH = C_MRD | C_IRL | C_PCI;

    typedef struct {
        logic       start;
        logic [3:0] op;
        logic       fc;
        logic       fz;
        logic       sm;
        logic       sp;
        logic [3:0] st;
        logic       hlt;
        logic [15:0] ctl;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic flag_c = 1'b0, flag_z = 1'b0, step_mode = 1'b0, step = 1'b0;

    logic [15:0] ctl0, ctl2;
    logic [3:0]  st0, st2;
    logic        h0, h2;
    logic        d0_mpc, d0_mir, d0_mrd, d0_mwr, d0_irl, d0_pci, d0_pcl, d0_ald;
    logic        d0_bld, d0_sub, d0_fld, d0_out, d0_done, d0_ill;
    logic [1:0]  d0_asrc;
    logic        d2_mpc, d2_mir, d2_mrd, d2_mwr, d2_irl, d2_pci, d2_pcl, d2_ald;
    logic        d2_bld, d2_sub, d2_fld, d2_out, d2_done, d2_ill;
    logic [1:0]  d2_asrc;

    int checks = 0;
    int failures = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    cpu_ctrl_seq #(.WAIT_MEM(0), .OP_W(4)) dut0 (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .flag_c(flag_c),
        .flag_z(flag_z), .step_mode(step_mode), .step(step),
        .mar_ld_pc(d0_mpc), .mar_ld_ir(d0_mir), .mem_rd(d0_mrd), .mem_wr(d0_mwr),
        .ir_ld(d0_irl), .pc_inc(d0_pci), .pc_ld(d0_pcl), .a_ld(d0_ald), .a_src(d0_asrc),
        .b_ld(d0_bld), .alu_sub(d0_sub), .flags_ld(d0_fld), .out_ld(d0_out),
        .instr_done(d0_done), .illegal(d0_ill), .halted(h0), .state(st0)
    );

    cpu_ctrl_seq #(.WAIT_MEM(2), .OP_W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .flag_c(flag_c),
        .flag_z(flag_z), .step_mode(step_mode), .step(step),
        .mar_ld_pc(d2_mpc), .mar_ld_ir(d2_mir), .mem_rd(d2_mrd), .mem_wr(d2_mwr),
        .ir_ld(d2_irl), .pc_inc(d2_pci), .pc_ld(d2_pcl), .a_ld(d2_ald), .a_src(d2_asrc),
        .b_ld(d2_bld), .alu_sub(d2_sub), .flags_ld(d2_fld), .out_ld(d2_out),
        .instr_done(d2_done), .illegal(d2_ill), .halted(h2), .state(st2)
    );

    assign ctl0 = {d0_mpc, d0_mir, d0_mrd, d0_mwr, d0_irl, d0_pci, d0_pcl, d0_ald,
                   d0_asrc, d0_bld, d0_sub, d0_fld, d0_out, d0_done, d0_ill};
    assign ctl2 = {d2_mpc, d2_mir, d2_mrd, d2_mwr, d2_irl, d2_pci, d2_pcl, d2_ald,
                   d2_asrc, d2_bld, d2_sub, d2_fld, d2_out, d2_done, d2_ill};

    function automatic vec_t v(input logic s, input logic [3:0] op, input logic fc,
                               input logic fz, input logic sm, input logic sp,
                               input logic [3:0] st, input logic h, input logic [15:0] c);
        vec_t r;
        r.start = s; r.op = op; r.fc = fc; r.fz = fz; r.sm = sm; r.sp = sp;
        r.st = st; r.hlt = h; r.ctl = c;
        return r;
    endfunction

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got state=%0d halted=%0b ctl=%04h, want state=%0d halted=%0b ctl=%04h",
                     name, act[20:17], act[16], act[15:0], exp[20:17], exp[16], exp[15:0]);
        end
    endtask

    task automatic sample_check(input int sel, input string name, input logic [3:0] st,
                                input logic h, input logic [15:0] c);
        if (sel == 0) check(name, {st0, h0, ctl0}, {st, h, c});
        else          check(name, {st2, h2, ctl2}, {st, h, c});
    endtask

    task automatic run_tbl(input int sel, input string tag);
        foreach (tbl[i]) begin
            @(negedge clk);
            start = tbl[i].start; opcode = tbl[i].op; flag_c = tbl[i].fc;
            flag_z = tbl[i].fz; step_mode = tbl[i].sm; step = tbl[i].sp;
            #1;
            sample_check(sel, $sformatf("%s[%0d]", tag, i), tbl[i].st, tbl[i].hlt, tbl[i].ctl);
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0; step_mode = 1'b0; step = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2;
        sample_check(0, "reset_dut0", E_IDLE, 1'b0, 16'h0);
        sample_check(2, "reset_dut2", E_IDLE, 1'b0, 16'h0);
        @(negedge clk);
        rst = 1'b0;

        // WAIT_MEM=0 instruction mix
        tbl.push_back(v(0, 0, 0, 0, 0, 0, E_IDLE, 0, 16'h0));
        tbl.push_back(v(1, 5, 0, 0, 0, 0, E_IDLE, 0, 16'h0));
        tbl.push_back(v(0, 5, 0, 0, 0, 0, E_F0, 0, C_MPC));
        tbl.push_back(v(1, 5, 0, 0, 0, 0, E_F1, 0, C_FETCH));
        tbl.push_back(v(0, 5, 0, 0, 0, 0, E_E0, 0, C_ALD | C_AS2 | C_DONE));
        tbl.push_back(v(0, 7, 0, 0, 0, 0, E_F0, 0, C_MPC));
        tbl.push_back(v(0, 7, 0, 0, 0, 0, E_F1, 0, C_FETCH));
        tbl.push_back(v(0, 7, 0, 1, 0, 0, E_E0, 0, C_DONE));
        tbl.push_back(v(0, 7, 1, 0, 0, 0, E_F0, 0, C_MPC));
        tbl.push_back(v(0, 7, 1, 0, 0, 0, E_F1, 0, C_FETCH));
        tbl.push_back(v(0, 7, 1, 0, 0, 0, E_E0, 0, C_PCL | C_DONE));
        tbl.push_back(v(0, 11, 0, 0, 0, 0, E_F0, 0, C_MPC));
        tbl.push_back(v(0, 11, 0, 0, 0, 0, E_F1, 0, C_FETCH));
        tbl.push_back(v(0, 11, 0, 0, 0, 0, E_E0, 0, C_ILL | C_DONE));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, E_F0, 0, C_MPC));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, E_F1, 0, C_FETCH));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, E_E0, 0, C_MIR));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, E_E1, 0, C_MRD | C_ALD | C_DONE));
        tbl.push_back(v(0, 3, 0, 1, 0, 0, E_F0, 0, C_MPC));
        tbl.push_back(v(0, 3, 0, 1, 0, 0, E_F1, 0, C_FETCH));
        tbl.push_back(v(0, 3, 0, 1, 0, 0, E_E0, 0, C_MIR));
        tbl.push_back(v(0, 3, 0, 1, 0, 0, E_E1, 0, C_MRD | C_BLD));
        tbl.push_back(v(0, 3, 0, 1, 0, 0, E_E2, 0, C_ALD | C_AS1 | C_FLD | C_SUB | C_DONE));
        tbl.push_back(v(0, 8, 0, 1, 0, 0, E_F0, 0, C_MPC));
        tbl.push_back(v(0, 8, 0, 1, 0, 0, E_F1, 0, C_FETCH));
        tbl.push_back(v(0, 8, 1, 1, 0, 0, E_E0, 0, C_PCL | C_DONE));
        tbl.push_back(v(0, 14, 0, 0, 0, 0, E_F0, 0, C_MPC));
        tbl.push_back(v(0, 14, 0, 0, 0, 0, E_F1, 0, C_FETCH));
        tbl.push_back(v(0, 14, 0, 0, 0, 0, E_E0, 0, C_OUT | C_DONE));
        tbl.push_back(v(0, 4, 0, 0, 0, 0, E_F0, 0, C_MPC));
        tbl.push_back(v(0, 4, 0, 0, 0, 0, E_F1, 0, C_FETCH));
        tbl.push_back(v(0, 4, 0, 0, 0, 0, E_E0, 0, C_MIR));
        tbl.push_back(v(0, 4, 0, 0, 0, 0, E_E1, 0, C_MWR | C_DONE));
        tbl.push_back(v(0, 15, 0, 0, 0, 0, E_F0, 0, C_MPC));
        tbl.push_back(v(0, 15, 0, 0, 0, 0, E_F1, 0, C_FETCH));
        tbl.push_back(v(0, 15, 0, 0, 0, 0, E_E0, 0, C_DONE));
        tbl.push_back(v(0, 15, 0, 0, 0, 0, E_HALT, 1, 16'h0));
        tbl.push_back(v(1, 15, 0, 0, 0, 0, E_HALT, 1, 16'h0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, E_F0, 0, C_MPC));
        run_tbl(0, "w0");

        // WAIT_MEM=2: ADD (9 cycles F0..E2), then STA interrupted by reset
        do_reset();
        tbl.push_back(v(1, 2, 0, 0, 0, 0, E_IDLE, 0, 16'h0));
        tbl.push_back(v(0, 2, 0, 0, 0, 0, E_F0, 0, C_MPC));
        tbl.push_back(v(0, 2, 0, 0, 0, 0, E_F1, 0, C_MRD));
        tbl.push_back(v(0, 2, 0, 0, 0, 0, E_F1, 0, C_MRD));
        tbl.push_back(v(0, 2, 0, 0, 0, 0, E_F1, 0, C_FETCH));
        tbl.push_back(v(0, 2, 0, 0, 0, 0, E_E0, 0, C_MIR));
        tbl.push_back(v(0, 2, 0, 0, 0, 0, E_E1, 0, C_MRD));
        tbl.push_back(v(0, 2, 0, 0, 0, 0, E_E1, 0, C_MRD));
        tbl.push_back(v(0, 2, 0, 0, 0, 0, E_E1, 0, C_MRD | C_BLD));
        tbl.push_back(v(0, 2, 1, 1, 0, 0, E_E2, 0, C_ALD | C_AS1 | C_FLD | C_DONE));
        tbl.push_back(v(0, 4, 0, 0, 0, 0, E_F0, 0, C_MPC));
        tbl.push_back(v(0, 4, 0, 0, 0, 0, E_F1, 0, C_MRD));
        tbl.push_back(v(0, 4, 0, 0, 0, 0, E_F1, 0, C_MRD));
        tbl.push_back(v(0, 4, 0, 0, 0, 0, E_F1, 0, C_FETCH));
        tbl.push_back(v(0, 4, 0, 0, 0, 0, E_E0, 0, C_MIR));
        tbl.push_back(v(0, 4, 0, 0, 0, 0, E_E1, 0, C_MWR));
        tbl.push_back(v(0, 4, 0, 0, 0, 0, E_E1, 0, C_MWR));
        run_tbl(2, "w2_add_sta");
        #1;
        rst = 1'b1;
        #1;
        sample_check(2, "sta_midreset", E_IDLE, 1'b0, 16'h0);
        @(negedge clk);
        rst = 1'b0;

        // WAIT_MEM=2: HLT holds for 10 cycles, then restarts on start
        tbl.push_back(v(1, 15, 0, 0, 0, 0, E_IDLE, 0, 16'h0));
        tbl.push_back(v(0, 15, 0, 0, 0, 0, E_F0, 0, C_MPC));
        tbl.push_back(v(0, 15, 0, 0, 0, 0, E_F1, 0, C_MRD));
        tbl.push_back(v(0, 15, 0, 0, 0, 0, E_F1, 0, C_MRD));
        tbl.push_back(v(0, 15, 0, 0, 0, 0, E_F1, 0, C_FETCH));
        tbl.push_back(v(0, 15, 1, 1, 0, 0, E_E0, 0, C_DONE));
        run_tbl(2, "w2_hlt");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            opcode = 4'(i);
            #1;
            sample_check(2, $sformatf("halt_hold[%0d]", i), E_HALT, 1'b1, 16'h0);
        end
        @(negedge clk);
        start = 1'b1;
        #1;
        sample_check(2, "halt_start", E_HALT, 1'b1, 16'h0);
        @(negedge clk);
        start = 1'b0;
        #1;
        sample_check(2, "halt_to_f0", E_F0, 1'b0, C_MPC);

        // Single-step behaviour on the WAIT_MEM=0 instance
        do_reset();
        tbl.push_back(v(1, 0, 0, 0, 1, 0, E_IDLE, 0, 16'h0));
        tbl.push_back(v(0, 0, 0, 0, 1, 1, E_F0, 0, C_MPC));
        tbl.push_back(v(0, 0, 0, 0, 1, 1, E_F1, 0, C_FETCH));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, E_E0, 0, C_DONE));
`ifdef CTRL_SINGLE_STEP_EN
        for (int i = 0; i < 5; i++) tbl.push_back(v(1, 0, 0, 0, 1, 0, E_WAIT, 0, 16'h0));
        tbl.push_back(v(0, 0, 0, 0, 1, 1, E_WAIT, 0, 16'h0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, E_F0, 0, C_MPC));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, E_F1, 0, C_FETCH));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, E_E0, 0, C_DONE));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, E_WAIT, 0, 16'h0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, E_WAIT, 0, 16'h0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, E_F0, 0, C_MPC));
`else
        tbl.push_back(v(0, 0, 0, 0, 1, 0, E_F0, 0, C_MPC));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, E_F1, 0, C_FETCH));
        tbl.push_back(v(0, 0, 0, 0, 1, 1, E_E0, 0, C_DONE));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, E_F0, 0, C_MPC));
`endif
        run_tbl(0, "step");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
